cache_ctrl_burst: RTL
=====================

Name: cache_ctrl_burst

Overview:
- Parametrised successor to the single-word cache control FSM, for a direct-mapped, write-through cache.
- Sequences CPU read and write requests against the cache array and a slow main memory.
- Read misses perform a multi-beat line fill of LINE_WORDS words, each beat separated by a programmable wait-state count.
- Sits between the CPU request interface (Strobe/DRW/DReady) and the cache datapath/memory strobes (W, WSel, RSel, MStrobe, MRW).

Parameters:
- WAIT_CYCLES, 4, memory wait states per beat; legal range 1..255.
- LINE_WORDS, 4, words per cache line fetched on a fill; power of 2, at least 1.
- BEAT_W, max(1,$clog2(LINE_WORDS)), width of the beat index (derived localparam, not overridable).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Strobe  in  1  CPU request valid; sampled only in IDLE.
- DRW  in  1  CPU request type; 1 = write, 0 = read. Sampled with Strobe.
- M  in  1  tag match from the tag RAM.
- V  in  1  valid bit from the tag RAM.
- DReady  out  1  request complete, 1-cycle pulse.
- W  out  1  cache array write enable.
- WSel  out  1  cache write-data select; 1 = memory data, 0 = CPU data.
- RSel  out  1  CPU read-data select; 1 = memory data, 0 = cache data.
- MStrobe  out  1  memory access start, 1-cycle pulse per beat.
- MRW  out  1  memory direction; 1 = write, 0 = read.
- BeatIdx  out  BEAT_W  word offset of the current fill beat; drives the cache/memory low address bits.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait counter=0, BeatIdx=0, alloc flag=0, all outputs 0. Asserting reset mid-transaction aborts it immediately; no DReady is issued.
- Outputs are decoded from state. The only input-dependent outputs are DReady and W in the CHK states.
- Strobe and DRW are ignored outside IDLE. No queuing of requests.

State machine:
- IDLE
  - Strobe=1, DRW=0 -> RD_CHK.
  - Strobe=1, DRW=1 -> WR_CHK.
  - Otherwise stay in IDLE.
- RD_CHK
  - If M&V: DReady=1, RSel=0, next state IDLE (hit; one cycle after Strobe).
  - Else: BeatIdx<=0, next state RD_MISS.
- RD_MISS
  - MStrobe=1, MRW=0.
  - Wait counter <= WAIT_CYCLES-1.
  - Next state RD_MEM.
- RD_MEM
  - MRW=0.
  - Counter decrements each cycle; when counter==0 -> RD_FILL. Total dwell is exactly WAIT_CYCLES cycles.
- RD_FILL
  - W=1, WSel=1.
  - If BeatIdx==LINE_WORDS-1: next state RD_DONE.
  - Else: BeatIdx<=BeatIdx+1, next state RD_MISS.
  - No wrap-around: BeatIdx never exceeds LINE_WORDS-1.
- RD_DONE
  - DReady=1, RSel=1.
  - BeatIdx<=0, next state IDLE (alloc flag set: see Optional Feature).
- WR_CHK
  - W=M&V, WSel=0 (write-hit cache update).
  - Next state WR_REQ. Write misses do not touch the cache.
- WR_REQ
  - MStrobe=1, MRW=1.
  - Counter <= WAIT_CYCLES-1, next state WR_MEM.
- WR_MEM
  - MRW=1.
  - Counter==0 -> WR_DONE.
- WR_DONE
  - DReady=1, MRW=1, next state IDLE.

Latencies, counting from the IDLE edge that samples Strobe as cycle 0:
- Read hit: DReady in cycle 1.
- Read miss: DReady in cycle 2+LINE_WORDS*(WAIT_CYCLES+2). With defaults this is cycle 26.
- Write: DReady in cycle 3+WAIT_CYCLES. With defaults this is cycle 7.

Boundary cases:
- WAIT_CYCLES=1: RD_MEM/WR_MEM last exactly one cycle.
- LINE_WORDS=1: single beat, BeatIdx held at 0.
- Strobe held high across DReady: a new request starts from IDLE on the cycle after DReady (back-to-back, no idle bubble beyond IDLE itself).

Optional Feature:
- Macro: CACHE_CTRL_WRITE_ALLOCATE_EN.
- Defined:
  - A write miss in WR_CHK sets the alloc flag and enters RD_MISS with BeatIdx<=0, performing the full line fill.
  - RD_DONE with alloc=1 issues no DReady and goes to WR_UPD.
  - WR_UPD: W=1, WSel=0, alloc<=0, next state WR_REQ (then write-through as normal).
  - Write-miss DReady with defaults occurs in cycle 2+24+1+1+4+1 = 33.
- Undefined:
  - No alloc flag or WR_UPD state.
  - A write miss is write-through only, with W=0.

Test Plan:
1. Reset low for 3 cycles mid-RD_MEM, then release -> all outputs 0 and BeatIdx=0 during reset; Busy=0; next Strobe is accepted normally.
2. Read hit: Strobe=1, DRW=0, M=V=1 -> DReady=1 and RSel=0 in cycle 1; W=0 and MStrobe=0 throughout.
3. Read miss, defaults, M=0 -> four MStrobe pulses with MRW=0, in cycles 2, 8, 14, 20; W=1/WSel=1 in cycles 7, 13, 19, 25 with BeatIdx 0, 1, 2, 3; DReady=1, RSel=1 in cycle 26.
4. Write hit, defaults, M=V=1 -> W=1, WSel=0 in cycle 1; MStrobe=1, MRW=1 in cycle 2; DReady in cycle 7. Write miss -> same timing with W=0.
5. Strobe toggled during a miss in RD_MEM -> ignored; no state change, no extra MStrobe. Back-to-back read hits with Strobe held high -> DReady in cycles 1 and 3.
6. With CACHE_CTRL_WRITE_ALLOCATE_EN, write miss, defaults -> line fill as in scenario 3 with no DReady in cycle 26; W=1, WSel=0 in cycle 27; MStrobe/MRW=1 in cycle 28; DReady in cycle 33. With WAIT_CYCLES=1, LINE_WORDS=1, read miss -> DReady in cycle 5.

Source files
------------

// File: rtl/cache_ctrl_burst.sv
// cache_ctrl_burst: control FSM for a direct-mapped, write-through cache with
// multi-beat line fill. Each fill beat pulses MStrobe, waits WAIT_CYCLES
// memory cycles, then writes one word into the cache array at BeatIdx.
// Optional macro CACHE_CTRL_WRITE_ALLOCATE_EN: write misses fill the line,
// update the cache word, then write through to memory.
module cache_ctrl_burst #(
    parameter int WAIT_CYCLES = 4,
    parameter int LINE_WORDS  = 4,
    localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Strobe,
    input  logic              DRW,
    input  logic              M,
    input  logic              V,
    output logic              DReady,
    output logic              W,
    output logic              WSel,
    output logic              RSel,
    output logic              MStrobe,
    output logic              MRW,
    output logic [BEAT_W-1:0] BeatIdx,
    output logic              Busy
);

    typedef enum logic [3:0] {
        IDLE, RD_CHK, RD_MISS, RD_MEM, RD_FILL, RD_DONE,
        WR_CHK, WR_REQ, WR_MEM, WR_DONE
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
        , WR_UPD
`endif
    } state_t;

    localparam logic [7:0]        CNT_LOAD  = 8'(WAIT_CYCLES - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    state_t            state;
    logic [7:0]        cnt;
    logic [BEAT_W-1:0] beat_idx;
    logic              hit;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
    logic              alloc;
`endif

    assign hit     = M & V;
    assign BeatIdx = beat_idx;

    // State, wait counter, beat index and allocate flag sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            beat_idx <= '0;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
            alloc    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Strobe) state <= DRW ? WR_CHK : RD_CHK;
                end
                RD_CHK: begin
                    if (hit) begin
                        state <= IDLE;
                    end else begin
                        beat_idx <= '0;
                        state    <= RD_MISS;
                    end
                end
                RD_MISS: begin
                    cnt   <= CNT_LOAD;
                    state <= RD_MEM;
                end
                // Dwell is CNT_LOAD+1 = WAIT_CYCLES cycles
                RD_MEM: begin
                    if (cnt == 8'd0) state <= RD_FILL;
                    else             cnt   <= cnt - 8'd1;
                end
                RD_FILL: begin
                    if (beat_idx == LAST_BEAT) begin
                        state <= RD_DONE;
                    end else begin
                        beat_idx <= beat_idx + BEAT_W'(1);
                        state    <= RD_MISS;
                    end
                end
                RD_DONE: begin
                    beat_idx <= '0;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
                    state    <= alloc ? WR_UPD : IDLE;
`else
                    state    <= IDLE;
`endif
                end
                WR_CHK: begin
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
                    if (!hit) begin
                        alloc    <= 1'b1;
                        beat_idx <= '0;
                        state    <= RD_MISS;
                    end else begin
                        state    <= WR_REQ;
                    end
`else
                    state <= WR_REQ;
`endif
                end
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
                WR_UPD: begin
                    alloc <= 1'b0;
                    state <= WR_REQ;
                end
`endif
                WR_REQ: begin
                    cnt   <= CNT_LOAD;
                    state <= WR_MEM;
                end
                WR_MEM: begin
                    if (cnt == 8'd0) state <= WR_DONE;
                    else             cnt   <= cnt - 8'd1;
                end
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from the state register; only the CHK states look at M/V
    always_comb begin
        DReady  = 1'b0;
        W       = 1'b0;
        WSel    = 1'b0;
        RSel    = 1'b0;
        MStrobe = 1'b0;
        MRW     = 1'b0;
        Busy    = (state != IDLE);
        case (state)
            RD_CHK:  DReady = hit;
            RD_MISS: MStrobe = 1'b1;
            RD_FILL: begin
                W    = 1'b1;
                WSel = 1'b1;
            end
            RD_DONE: begin
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
                DReady = !alloc;
`else
                DReady = 1'b1;
`endif
                RSel   = 1'b1;
            end
            WR_CHK:  W = hit;
`ifdef CACHE_CTRL_WRITE_ALLOCATE_EN
            WR_UPD:  W = 1'b1;
`endif
            WR_REQ: begin
                MStrobe = 1'b1;
                MRW     = 1'b1;
            end
            WR_MEM:  MRW = 1'b1;
            WR_DONE: begin
                DReady = 1'b1;
                MRW    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
